// File: rtl/dtb_pkg.sv
// Shared trace-buffer definitions: sizing constants, control/status words and helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dtb_pkg;

  localparam int TRB_WIDTH       = 32;
  // Must be a power of two: pointers wrap by natural overflow.
  localparam int TRB_DEPTH       = 64;
  localparam int TRB_ADDR_WIDTH  = $clog2(TRB_DEPTH);
  localparam int TRB_MODE_BITS   = 1;
  localparam int TRB_NTRACE_BITS = 2;
  localparam int TRB_DELAY_BITS  = 3;
  localparam int TRB_POS_BITS    = $clog2(TRB_WIDTH);

  typedef enum logic [TRB_MODE_BITS-1:0] {
    trace_mode   = 1'b0,   // streaming FIFO, stalls when full
    capture_mode = 1'b1    // ring buffer, freezes after the delayed trigger
  } trg_mode_t;

  typedef struct packed {
    trg_mode_t                  trg_mode;
    logic [TRB_NTRACE_BITS-1:0] trg_num_traces;
    logic [TRB_DELAY_BITS-1:0]  trg_delay;
  } control_t;

  typedef struct packed {
    logic                      trg_event;
    logic [TRB_POS_BITS-1:0]   event_pos;
    logic [TRB_ADDR_WIDTH-1:0] event_addr;
  } status_t;

  localparam control_t CONTROL_DEFAULT = '{
    trg_mode:       trace_mode,
    trg_num_traces: '0,
    trg_delay:      '0
  };

  // Trigger-delay sequencer states.
  typedef enum logic [1:0] {
    TRG_IDLE  = 2'd0,   // armed, waiting for an event
    TRG_COUNT = 2'd1,   // event seen, counting accepted stores
    TRG_FIRED = 2'd2    // delayed trigger has fired (sticky)
  } trg_state_t;

  // Circular pointer increment; wraps modulo TRB_DEPTH.
  function automatic logic [TRB_ADDR_WIDTH-1:0] ptr_inc(input logic [TRB_ADDR_WIDTH-1:0] p);
    return p + TRB_ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/logger.sv
// Trace-buffer controller: circular write/read pointers, store/load paths, delayed trigger.
// Latency: store->WRITE_O at next write slot (<=2 cycles); load request->LOAD_GRANT_O <=4-5 cycles.
// Backpressure: STORE_PERM_O drops while a write is pending, when full (trace mode) or once stopped.
//
// Ports:
//   CLK_I, RST_I                 clock, asynchronous active-high reset
//   CONTROL_I / STATUS_O         mode, num traces, trigger delay / trigger flag, position, address
//   RW_TURN_I                    memory slot owner: 1 = write slot, 0 = read slot
//   WRITE_O, WRITE_PTR_O, DMEM_O memory write strobe, address, data
//   READ_PTR_O, DMEM_I           memory read address, read data
//   WRITE_ALLOW_I, READ_ALLOW_I  side enables
//   MODE_O, NTRACE_O             control pass-throughs
//   EVENT_POS_I, TRG_EVENT_I     trigger position and pulse; TRG_DELAYED_O sticky fired flag
//   DATA_I, STORE_I, STORE_PERM_O       store side
//   DATA_O, LOAD_REQUEST_I, LOAD_GRANT_O load side
module logger
  import dtb_pkg::*;
(
  input  logic                       CLK_I,
  input  logic                       RST_I,
  input  control_t                   CONTROL_I,
  output status_t                    STATUS_O,
  input  logic                       RW_TURN_I,
  output logic                       WRITE_O,
  input  logic                       WRITE_ALLOW_I,
  input  logic                       READ_ALLOW_I,
  output logic [TRB_ADDR_WIDTH-1:0]  READ_PTR_O,
  input  logic [TRB_WIDTH-1:0]       DMEM_I,
  output logic [TRB_ADDR_WIDTH-1:0]  WRITE_PTR_O,
  output logic [TRB_WIDTH-1:0]       DMEM_O,
  output logic [TRB_MODE_BITS-1:0]   MODE_O,
  output logic [TRB_NTRACE_BITS-1:0] NTRACE_O,
  input  logic [TRB_POS_BITS-1:0]    EVENT_POS_I,
  input  logic                       TRG_EVENT_I,
  output logic                       TRG_DELAYED_O,
  output logic [TRB_WIDTH-1:0]       DATA_O,
  input  logic                       LOAD_REQUEST_I,
  output logic                       LOAD_GRANT_O,
  input  logic [TRB_WIDTH-1:0]       DATA_I,
  input  logic                       STORE_I,
  output logic                       STORE_PERM_O
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TRB_ADDR_WIDTH-1:0] write_ptr;    // next free slot
  logic [TRB_ADDR_WIDTH-1:0] read_ptr;     // last slot read
  logic                      write_pending;
  logic [TRB_WIDTH-1:0]      dmem_q;
  logic                      load_pending;
  logic                      load_stage;   // read_ptr advanced, data due next read slot
  logic [TRB_WIDTH-1:0]      data_q;
  logic                      grant_q;

  trg_state_t                trg_state, trg_state_nxt;
  logic [TRB_DELAY_BITS-1:0] delay_cnt, delay_cnt_nxt;
  logic [TRB_POS_BITS-1:0]   event_pos_q, event_pos_nxt;
  logic [TRB_ADDR_WIDTH-1:0] event_addr_q, event_addr_nxt;

  // ---------------------------------------------------------------------------
  // Derived conditions
  // ---------------------------------------------------------------------------
  logic full, empty, capture, fired, stopped;
  logic store_perm, store_acc, do_write, load_advance, load_finish;

  assign full    = (write_ptr == read_ptr);
  assign empty   = (ptr_inc(read_ptr) == write_ptr);
  assign capture = (CONTROL_I.trg_mode == capture_mode);
  assign fired   = (trg_state == TRG_FIRED);
  // Only the ring-buffer mode freezes on the trigger; trace mode keeps streaming.
  assign stopped = capture & fired;

  // A full buffer still accepts in capture mode; the oldest entry is overwritten.
  assign store_perm = WRITE_ALLOW_I & ~write_pending & ~stopped & (~full | capture);
  assign store_acc  = STORE_I & store_perm;
  assign do_write   = RW_TURN_I & write_pending;

  assign load_advance = ~RW_TURN_I & load_pending & ~load_stage & READ_ALLOW_I & ~empty;
  assign load_finish  = ~RW_TURN_I & load_stage;

  // ---------------------------------------------------------------------------
  // Store / load datapath and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      write_ptr     <= '0;
      read_ptr      <= '1;
      write_pending <= 1'b0;
      dmem_q        <= '0;
      load_pending  <= 1'b0;
      load_stage    <= 1'b0;
      data_q        <= '0;
      grant_q       <= 1'b0;
    end else begin
      // store_acc requires ~write_pending, so it never collides with do_write.
      if (store_acc) begin
        dmem_q        <= DATA_I;
        write_pending <= 1'b1;
      end else if (do_write) begin
        write_pending <= 1'b0;
      end

      // Write and read slots are disjoint, so only one side moves pointers per cycle.
      if (do_write) begin
        write_ptr <= ptr_inc(write_ptr);
        if (full && capture) begin
          read_ptr <= ptr_inc(read_ptr);
        end
      end else if (load_advance) begin
        read_ptr <= ptr_inc(read_ptr);
      end

      // A new request is never lost, even if it lands on the completing cycle.
      load_pending <= LOAD_REQUEST_I | (load_pending & ~load_finish);

      if (load_advance) begin
        load_stage <= 1'b1;
      end else if (load_finish) begin
        load_stage <= 1'b0;
      end

      grant_q <= load_finish;
      if (load_finish) begin
        data_q <= DMEM_I;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Trigger-delay sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      trg_state    <= TRG_IDLE;
      delay_cnt    <= '0;
      event_pos_q  <= '0;
      event_addr_q <= '0;
    end else begin
      trg_state    <= trg_state_nxt;
      delay_cnt    <= delay_cnt_nxt;
      event_pos_q  <= event_pos_nxt;
      event_addr_q <= event_addr_nxt;
    end
  end

  always_comb begin
    trg_state_nxt  = trg_state;
    delay_cnt_nxt  = delay_cnt;
    event_pos_nxt  = event_pos_q;
    event_addr_nxt = event_addr_q;
    unique case (trg_state)
      TRG_IDLE: begin
        if (TRG_EVENT_I) begin
          event_pos_nxt = EVENT_POS_I;
          delay_cnt_nxt = CONTROL_I.trg_delay;
          // Zero delay fires straight away so the flag shows the cycle after the event.
          if (CONTROL_I.trg_delay == '0) begin
            trg_state_nxt  = TRG_FIRED;
            event_addr_nxt = write_ptr;
          end else begin
            trg_state_nxt = TRG_COUNT;
          end
        end
      end
      TRG_COUNT: begin
        if (store_acc) begin
          delay_cnt_nxt = delay_cnt - TRB_DELAY_BITS'(1);
          // No write can be pending when a store is accepted, so write_ptr is
          // the slot this final store will land in.
          if (delay_cnt == TRB_DELAY_BITS'(1)) begin
            trg_state_nxt  = TRG_FIRED;
            event_addr_nxt = write_ptr;
          end
        end
      end
      TRG_FIRED: begin
        trg_state_nxt = TRG_FIRED;
      end
      default: begin
        trg_state_nxt = TRG_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    STATUS_O           = '0;
    STATUS_O.trg_event = fired;
    if (fired) begin
      STATUS_O.event_pos  = event_pos_q;
      STATUS_O.event_addr = event_addr_q;
    end
  end

  assign WRITE_O       = do_write;
  assign WRITE_PTR_O   = write_ptr;
  assign READ_PTR_O    = read_ptr;
  assign DMEM_O        = dmem_q;
  assign DATA_O        = data_q;
  assign LOAD_GRANT_O  = grant_q;
  assign STORE_PERM_O  = store_perm;
  assign TRG_DELAYED_O = fired;
  assign MODE_O        = CONTROL_I.trg_mode;
  assign NTRACE_O      = CONTROL_I.trg_num_traces;

endmodule

// File: tb/tb_logger.sv
// Self-checking bench for logger: reset/handshake vector table, randomized trace fill
// against a FIFO occupancy model, load path, trigger-delay sweep, capture wrap, reset abort.
module tb_logger;
  import dtb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst;
  control_t                   control;
  status_t                    status;
  logic                       rw_turn, write_o, write_allow, read_allow;
  logic [TRB_ADDR_WIDTH-1:0]  read_ptr_o, write_ptr_o;
  logic [TRB_WIDTH-1:0]       dmem_i, dmem_o, data_o, data_i;
  logic [TRB_MODE_BITS-1:0]   mode_o;
  logic [TRB_NTRACE_BITS-1:0] ntrace_o;
  logic [TRB_POS_BITS-1:0]    event_pos;
  logic                       trg_event, trg_delayed_o, load_req, load_grant_o;
  logic                       store_i, store_perm_o;

  logger dut (
    .CLK_I(clk), .RST_I(rst), .CONTROL_I(control), .STATUS_O(status),
    .RW_TURN_I(rw_turn), .WRITE_O(write_o), .WRITE_ALLOW_I(write_allow),
    .READ_ALLOW_I(read_allow), .READ_PTR_O(read_ptr_o), .DMEM_I(dmem_i),
    .WRITE_PTR_O(write_ptr_o), .DMEM_O(dmem_o), .MODE_O(mode_o), .NTRACE_O(ntrace_o),
    .EVENT_POS_I(event_pos), .TRG_EVENT_I(trg_event), .TRG_DELAYED_O(trg_delayed_o),
    .DATA_O(data_o), .LOAD_REQUEST_I(load_req), .LOAD_GRANT_O(load_grant_o),
    .DATA_I(data_i), .STORE_I(store_i), .STORE_PERM_O(store_perm_o)
  );

  // Single-port trace memory with asynchronous read.
  logic [TRB_WIDTH-1:0] mem [TRB_DEPTH];
  always @(posedge clk) if (write_o) mem[write_ptr_o] <= dmem_o;
  assign dmem_i = mem[read_ptr_o];

  int n_checks = 0;
  int n_fail   = 0;
  bit auto_rw  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_rw) rw_turn = ~rw_turn;
  endtask

  task automatic do_reset(input control_t c);
    rst = 1'b1; control = c; store_i = 1'b0; load_req = 1'b0; trg_event = 1'b0;
    write_allow = 1'b0; read_allow = 1'b0; rw_turn = 1'b0; data_i = '0; event_pos = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Hold STORE_I until the store is seen permitted before an edge (bounded).
  task automatic store_word(input logic [TRB_WIDTH-1:0] d, output bit ok);
    ok = 1'b0; data_i = d; store_i = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (store_perm_o) ok = 1'b1;
      tick();
    end
    store_i = 1'b0;
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (load_grant_o) got = 1'b1;
      else tick();
    end
  endtask

  typedef struct {
    logic rst, wa, st, rw;
    logic [31:0] d;
    logic perm, wo;
    logic [5:0] wp, rp;
    logic [31:0] dm;
  } vec_t;
  vec_t vt[9];

  logic [TRB_WIDTH-1:0] expq[$];
  logic [TRB_WIDTH-1:0] w, pend_d;
  bit ok, got, pend, exp_perm;
  int nwr, idle, grants, n_ok;
  control_t c;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; control = CONTROL_DEFAULT; store_i = 0; load_req = 0; trg_event = 0;
    write_allow = 0; read_allow = 0; rw_turn = 0; data_i = '0; event_pos = '0;

    // ---------------- reset and store handshake vectors ----------------
    //         rst wa st rw data          perm wo wp    rp     dmem_o
    vt[0] = '{1, 0, 0, 0, 32'h0,         0, 0, 6'd0, 6'd63, 32'h0};
    vt[1] = '{0, 0, 1, 1, 32'h0,         0, 0, 6'd0, 6'd63, 32'h0};
    vt[2] = '{0, 1, 0, 1, 32'h0,         1, 0, 6'd0, 6'd63, 32'h0};
    vt[3] = '{0, 1, 1, 0, 32'hA5A5_0001, 1, 0, 6'd0, 6'd63, 32'h0};
    vt[4] = '{0, 1, 1, 0, 32'h1234_0000, 0, 0, 6'd0, 6'd63, 32'hA5A5_0001};
    vt[5] = '{0, 1, 0, 1, 32'h0,         0, 1, 6'd0, 6'd63, 32'hA5A5_0001};
    vt[6] = '{0, 1, 0, 0, 32'h0,         1, 0, 6'd1, 6'd63, 32'hA5A5_0001};
    vt[7] = '{0, 0, 0, 1, 32'h0,         0, 0, 6'd1, 6'd63, 32'hA5A5_0001};
    vt[8] = '{1, 0, 0, 0, 32'h0,         0, 0, 6'd0, 6'd63, 32'h0};
    #1;
    chk("rst_grant", load_grant_o, 0);
    chk("rst_delayed", trg_delayed_o, 0);
    chk("rst_status", status, '0);
    chk("rst_data", data_o, 0);
    chk("rst_mode", mode_o, 0);
    for (int i = 0; i < 9; i++) begin
      rst = vt[i].rst; write_allow = vt[i].wa; store_i = vt[i].st;
      rw_turn = vt[i].rw; data_i = vt[i].d;
      #1;
      chk($sformatf("vec%0d_perm", i), store_perm_o, vt[i].perm);
      chk($sformatf("vec%0d_write", i), write_o, vt[i].wo);
      chk($sformatf("vec%0d_wptr", i), write_ptr_o, vt[i].wp);
      chk($sformatf("vec%0d_rptr", i), read_ptr_o, vt[i].rp);
      chk($sformatf("vec%0d_dmem", i), dmem_o, vt[i].dm);
      tick();
    end

    // ---------------- randomized trace-mode fill ----------------
    do_reset(CONTROL_DEFAULT);
    auto_rw = 1'b0; pend = 1'b0; nwr = 0; idle = 0;
    for (int cyc = 0; cyc < 4000 && idle < 30; cyc++) begin
      write_allow = ($urandom_range(3) != 0);
      store_i     = 1'($urandom_range(1));
      rw_turn     = 1'($urandom_range(1));
      data_i      = $urandom;
      #1;
      // No loads here, so occupancy is simply the number of completed writes.
      exp_perm = write_allow && !pend && (nwr < TRB_DEPTH - 1);
      chk("trace_perm", store_perm_o, exp_perm);
      chk("trace_write", write_o, pend && rw_turn);
      if (pend && rw_turn) begin
        chk("trace_waddr", write_ptr_o, nwr % TRB_DEPTH);
        chk("trace_wdata", dmem_o, pend_d);
        nwr++;
        pend = 1'b0;
      end else if (store_i && exp_perm) begin
        pend = 1'b1;
        pend_d = data_i;
      end
      if (nwr == TRB_DEPTH - 1) idle++;
      tick();
    end
    store_i = 1'b0;
    chk("trace_write_count", nwr, 63);
    write_allow = 1'b1; #1;
    chk("trace_full_perm", store_perm_o, 0);

    // ---------------- load path ----------------
    do_reset(CONTROL_DEFAULT);
    auto_rw = 1'b1; write_allow = 1'b1; read_allow = 1'b1;
    expq.delete();
    for (int k = 0; k < 5; k++) begin
      w = $urandom;
      store_word(w, ok);
      chk("ld_store_ok", ok, 1);
      expq.push_back(w);
    end
    tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin
      load_req = 1'b1; tick(); load_req = 1'b0;
      wait_grant(got);
      chk("ld_grant", got, 1);
      chk("ld_data", data_o, expq.pop_front());
      chk("ld_rptr", read_ptr_o, k);
      tick();
    end
    load_req = 1'b1; tick(); load_req = 1'b0;
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load_grant_o) grants++;
    end
    chk("ld_empty_no_grant", grants, 0);
    store_word(32'hBEEF_0001, ok);
    wait_grant(got);
    chk("ld_pending_grant", got, 1);
    chk("ld_pending_data", data_o, 32'hBEEF_0001);

    // ---------------- trigger-delay sweep ----------------
    for (int d = 7; d >= 0; d--) begin
      c = CONTROL_DEFAULT;
      c.trg_delay = d[2:0];
      do_reset(c);
      auto_rw = 1'b1; write_allow = 1'b1;
      trg_event = 1'b1; event_pos = 5'd13; tick(); trg_event = 1'b0; event_pos = 5'd5;
      if (d == 0) begin
        chk("sw_delay0", trg_delayed_o, 1);
      end else begin
        chk("sw_before", trg_delayed_o, 0);
        for (int n = 1; n <= d; n++) begin
          store_word($urandom, ok);
          chk("sw_store_ok", ok, 1);
          chk($sformatf("sw_d%0d_n%0d", d, n), trg_delayed_o, (n == d));
        end
      end
      chk("sw_evt", status.trg_event, 1);
      chk("sw_pos", status.event_pos, 13);
      chk("sw_addr", status.event_addr, (d == 0) ? 0 : d - 1);
      trg_event = 1'b1; event_pos = 5'd3; tick(); trg_event = 1'b0;
      chk("sw_pos_hold", status.event_pos, 13);
      chk("sw_sticky", trg_delayed_o, 1);
    end

    // ---------------- capture mode wrap and stop ----------------
    c = '{trg_mode: capture_mode, trg_num_traces: 2'd2, trg_delay: 3'd3};
    do_reset(c);
    auto_rw = 1'b1; write_allow = 1'b1;
    #1;
    chk("cap_mode_o", mode_o, 1);
    chk("cap_ntrace_o", ntrace_o, 2);
    expq.delete(); n_ok = 0;
    for (int i = 0; i < 67; i++) begin
      w = 32'h1000 + i;
      store_word(w, ok);
      if (ok) n_ok++;
      expq.push_back(w);
      if (expq.size() > TRB_DEPTH - 1) void'(expq.pop_front());
    end
    chk("cap_store_count", n_ok, 67);
    tick(); tick(); tick();
    chk("cap_wrap_wptr", write_ptr_o, 3);
    chk("cap_wrap_rptr", read_ptr_o, 3);
    #1;
    chk("cap_full_perm", store_perm_o, 1);
    trg_event = 1'b1; event_pos = 5'd9; tick(); trg_event = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      w = 32'h1000 + 66 + n;
      store_word(w, ok);
      chk("cap_post_ok", ok, 1);
      expq.push_back(w);
      if (expq.size() > TRB_DEPTH - 1) void'(expq.pop_front());
      chk($sformatf("cap_delayed_n%0d", n), trg_delayed_o, (n == 3));
    end
    chk("cap_stop_perm", store_perm_o, 0);
    tick(); tick(); tick();
    chk("cap_final_wptr", write_ptr_o, 6);
    chk("cap_final_rptr", read_ptr_o, 6);
    chk("cap_evt_addr", status.event_addr, 5);
    chk("cap_evt_pos", status.event_pos, 9);
    store_word(32'hDEAD_0000, ok);
    chk("cap_stopped_store", ok, 0);
    read_allow = 1'b1;
    load_req = 1'b1; tick(); load_req = 1'b0;
    wait_grant(got);
    chk("cap_drain_grant", got, 1);
    chk("cap_drain_data", data_o, expq[0]);

    // ---------------- reset during a pending write ----------------
    do_reset(CONTROL_DEFAULT);
    auto_rw = 1'b0; rw_turn = 1'b0; write_allow = 1'b1;
    store_word(32'hCAFE_0000, ok);
    chk("rw_store_ok", ok, 1);
    #2;
    rst = 1'b1; rw_turn = 1'b1;
    #1;
    chk("rw_abort_write", write_o, 0);
    chk("rw_abort_wptr", write_ptr_o, 0);
    chk("rw_abort_rptr", read_ptr_o, 63);
    tick();
    rst = 1'b0;
    #1;
    chk("rw_after_write", write_o, 0);
    tick();
    chk("rw_after_wptr", write_ptr_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
